alu_sequencer: RTL
==================

# alu_sequencer

Front-end controller for the 8-bit serial ALU: accepts one operation request (op, X, Y) over a valid/ready handshake and drives the ALU's BEGIN/op_code/inbus sequence. It then waits for END, assembles the 8- or 16-bit result from outbus, and returns it over a second valid/ready handshake. A watchdog aborts hung operations, pulses the ALU reset and reports an error. The block sits between the system-side requester and the ALU instance and owns every ALU control input.

## Interface
- TIMEOUT_CYCLES, 64: maximum number of WAIT cycles before abort; must be ≥2. The counter width is derived via $clog2.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 add, 01 sub, 10 mul (radix-4), 11 div (SRT-2).
- req_x  in  8  first operand (multiplicand or dividend).
- req_y  in  8  second operand (multiplier or divisor).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  16  result: {8'h00, byte} for add/sub; {first byte, END byte} for mul/div.
- rsp_error  out  1  qualifies rsp_valid; 1 means the operation timed out.
- alu_begin  out  1  to ALU BEGIN.
- alu_op_code  out  2  to ALU op_code.
- alu_inbus  out  8  to ALU inbus.
- alu_outbus  in  8  from ALU outbus.
- alu_end  in  1  from ALU END.
- alu_reset  out  1  to ALU reset, active-high.

## Operation
- States:
  - IDLE: req_ready=1. On req_valid, capture op, x and y into internal registers, then go to START.
  - START: alu_begin=1 and alu_op_code=op. Go to LOAD_X.
  - LOAD_X: alu_inbus=x. Go to LOAD_Y.
  - LOAD_Y: alu_inbus=y. Clear the timeout counter. Go to WAIT.
  - WAIT: each cycle, register alu_outbus into prev_byte and increment the counter.
    - If alu_end=1: rsp_data = op[1] ? {prev_byte, alu_outbus} : {8'h00, alu_outbus}; rsp_error=0; go to RESP.
    - Else if counter == TIMEOUT_CYCLES-1: go to FLUSH.
  - FLUSH: alu_reset=1 for exactly one cycle; rsp_data=0; rsp_error=1. Go to RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_error are held stable until rsp_ready=1, then go to IDLE.
- alu_op_code holds the captured op from START through WAIT. It is 00 in IDLE, FLUSH and RESP.
- alu_inbus is 8'h00 outside LOAD_X and LOAD_Y. alu_begin is 0 outside START.
- req_ready=1 only in IDLE. A new request cannot be accepted in the same cycle a response is consumed.
- alu_end is ignored outside WAIT, including any spurious or late END.
- If alu_end=1 and the timeout is reached in the same cycle, END wins and a normal result is returned.
- For mul/div, prev_byte is the outbus value from the cycle before END. If END arrives in the first WAIT cycle, prev_byte is 8'h00.
- Request fields are sampled only on acceptance; later changes to req_* have no effect.

## Timing
- Reset (reset=0, asynchronous):
  - State goes to IDLE; req_ready=1.
  - rsp_valid, rsp_error, rsp_data, alu_begin, alu_op_code, alu_inbus, the counter and prev_byte all go to 0.
  - alu_reset=1 for the whole time reset is low, combinationally from reset.
- Reset mid-operation aborts immediately and produces no response.
- All other outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Cycle numbering from request acceptance (req_valid & req_ready) at edge 0:
  - Cycle 1: START (alu_begin pulse).
  - Cycle 2: LOAD_X (X on inbus).
  - Cycle 3: LOAD_Y (Y on inbus).
  - Cycle 4 onward: WAIT.
- END sampled in cycle k gives rsp_valid from cycle k+1. Minimum request-to-response latency is 5 cycles.
- With no END, FLUSH occurs in cycle 4+TIMEOUT_CYCLES and rsp_valid in cycle 5+TIMEOUT_CYCLES.
- Throughput: at most one operation in flight. The next acceptance is no earlier than one cycle after the response handshake.

## Test plan
- Add: req op=00, x=0x12, y=0x34. ALU model drives outbus=0x46 with END 6 cycles into WAIT. Expect:
  - alu_begin pulse in cycle 1, inbus 0x12 in cycle 2, inbus 0x34 in cycle 3;
  - rsp_valid one cycle after END with rsp_data=0x0046, rsp_error=0.
- Mul: op=10, x=0x14, y=0x14. Outbus=0x01, then 0x90 with END. Expect rsp_data=0x0190. Repeat with op=11 and bytes 0x07/0x03: expect rsp_data=0x0703.
- Timeout: TIMEOUT_CYCLES=8, END never asserted. Expect:
  - FLUSH exactly 8 cycles after WAIT entry, with a single-cycle alu_reset;
  - rsp_valid next cycle with rsp_error=1, rsp_data=0.
- Backpressure and spurious END:
  - hold rsp_ready=0 for 3 cycles: rsp_valid and rsp_data stay stable, req_ready=0, and a pending req_valid is not accepted;
  - pulse alu_end while in IDLE and in LOAD_X: no state change and no response.
- Boundary: END on the same cycle the counter hits TIMEOUT_CYCLES-1. Expect a normal result, rsp_error=0 and no alu_reset pulse.
- Reset mid-WAIT: assert reset asynchronously between edges. Expect:
  - alu_reset=1 and all other outputs at reset values immediately;
  - after release, req_ready=1, no stale response, and a fresh add completes correctly.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: front-end controller for the 8-bit serial ALU.
// Accepts one request (op, X, Y), sequences BEGIN/op_code/inbus, waits for END,
// assembles the result, and returns it. A watchdog aborts hung operations.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a request; captures op/x/y on acceptance
// START   | BEGIN pulse with op_code driven
// LOAD_X  | first operand on inbus
// LOAD_Y  | second operand on inbus; watchdog and prev_byte cleared
// WAIT    | waiting for END; tracks previous outbus byte
// FLUSH   | watchdog expired; one-cycle ALU reset, error result latched
// RESP    | result presented until the consumer takes it
`timescale 1ns/1ps

module alu_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end,
    output logic        alu_reset
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_X,
        S_LOAD_Y,
        S_WAIT,
        S_FLUSH,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_op;
    logic [7:0]     r_x;
    logic [7:0]     r_y;
    logic [7:0]     r_prev;
    logic [CW-1:0]  r_cnt;
    logic [15:0]    r_rsp_data;
    logic           r_rsp_error;
    logic           w_timeout;
    logic           w_op_active;

    assign w_timeout = (r_cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; END takes priority over the watchdog in WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = S_START;
            S_START:  w_next = S_LOAD_X;
            S_LOAD_X: w_next = S_LOAD_Y;
            S_LOAD_Y: w_next = S_WAIT;
            S_WAIT: begin
                if (alu_end) begin
                    w_next = S_RESP;
                end else if (w_timeout) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH:  w_next = S_RESP;
            S_RESP:   if (rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Request capture, watchdog counter, previous-byte tracking and result latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op        <= 2'b00;
            r_x         <= 8'h00;
            r_y         <= 8'h00;
            r_prev      <= 8'h00;
            r_cnt       <= '0;
            r_rsp_data  <= 16'h0000;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op <= req_op;
                        r_x  <= req_x;
                        r_y  <= req_y;
                    end
                end
                S_LOAD_Y: begin
                    r_cnt  <= '0;
                    r_prev <= 8'h00;
                end
                S_WAIT: begin
                    r_prev <= alu_outbus;
                    r_cnt  <= r_cnt + CW'(1);
                    if (alu_end) begin
                        // mul/div return two bytes: the one before END is the high byte.
                        r_rsp_data  <= r_op[1] ? {r_prev, alu_outbus} : {8'h00, alu_outbus};
                        r_rsp_error <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    r_rsp_data  <= 16'h0000;
                    r_rsp_error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_op_active = (r_state == S_START) || (r_state == S_LOAD_X) ||
                         (r_state == S_LOAD_Y) || (r_state == S_WAIT);

    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_data    = r_rsp_data;
    assign rsp_error   = r_rsp_error;
    assign alu_begin   = (r_state == S_START);
    assign alu_op_code = w_op_active ? r_op : 2'b00;
    assign alu_inbus   = (r_state == S_LOAD_X) ? r_x :
                         (r_state == S_LOAD_Y) ? r_y : 8'h00;
    // The ALU is held in reset for as long as the sequencer is.
    assign alu_reset   = !reset || (r_state == S_FLUSH);

endmodule
